// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared widths and types for the BCP clause arbiter
`ifndef BCP_CLAUSE_NUM
`define BCP_CLAUSE_NUM 8
`endif
`ifndef BCP_CLAUSE_NUM_LOG
`define BCP_CLAUSE_NUM_LOG 3
`endif

package bcp_pkg;
    localparam int CLAUSE_NUM_P     = `BCP_CLAUSE_NUM;
    localparam int CLAUSE_NUM_LOG_P = `BCP_CLAUSE_NUM_LOG;

    typedef logic [`BCP_CLAUSE_NUM_LOG-1:0] clause_idx_t;
    typedef logic [`BCP_CLAUSE_NUM-1:0]     clause_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        HALT
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate / priority-encode / un-rotate round-robin picker
module rr_pick #(
    parameter int N   = `BCP_CLAUSE_NUM,
    parameter int LOG = `BCP_CLAUSE_NUM_LOG
) (
    input  logic [N-1:0]   cand,
    input  logic [LOG-1:0] ptr,
    output logic           found,
    output logic [LOG-1:0] idx
);
    logic [N-1:0] rot;
    logic [LOG:0] off;
    logic [LOG:0] sum;

    always_comb begin
        // rot[0] corresponds to the clause at the pointer
        for (int i = 0; i < N; i++) begin
            rot[i] = cand[(i + int'(ptr)) % N];
        end
        found = |rot;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = (LOG+1)'(i);
            end
        end
        sum = off + {1'b0, ptr};
        if (sum >= (LOG+1)'(N)) begin
            sum = sum - (LOG+1)'(N);
        end
        idx = sum[LOG-1:0];
    end
endmodule

// File: rtl/bcp_clause_arbiter.sv
// rtl/bcp_clause_arbiter.sv - round-robin arbiter for the BCP implication/conflict return path
module bcp_clause_arbiter
    import bcp_pkg::*;
#(
    parameter int CLAUSE_NUM     = `BCP_CLAUSE_NUM,
    parameter int CLAUSE_NUM_LOG = `BCP_CLAUSE_NUM_LOG
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CLAUSE_NUM-1:0]     req,
    input  logic [CLAUSE_NUM-1:0]     conf,
    input  logic                      flush,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [CLAUSE_NUM_LOG-1:0] out_idx,
    output logic                      out_conflict,
    output logic [CLAUSE_NUM-1:0]     gnt_onehot,
    output logic                      halted
);
    arb_state_t                state, state_nxt;
    logic [CLAUSE_NUM_LOG-1:0] ptr, ptr_nxt;
    logic                      valid_nxt, confl_nxt, halted_nxt;
    logic [CLAUSE_NUM_LOG-1:0] idx_nxt;
    logic [CLAUSE_NUM-1:0]     gnt_nxt;

    logic                      accept;
    logic [CLAUSE_NUM-1:0]     granted;
    logic [CLAUSE_NUM_LOG-1:0] idx_inc;
    logic [CLAUSE_NUM-1:0]     mreq, mconf, pick_cand;
    logic [CLAUSE_NUM_LOG-1:0] pick_ptr, pick_idx;
    logic                      pick_found;

    assign accept  = out_valid & out_ready;
    assign granted = CLAUSE_NUM'(1) << out_idx;
    assign idx_inc = (out_idx == CLAUSE_NUM_LOG'(CLAUSE_NUM - 1)) ? '0 : out_idx + 1'b1;

    // In OFFER the only pick that matters is the back-to-back re-pick, so the
    // offered bit is masked and the search restarts just past it.
    assign mreq      = (state == OFFER) ? (req & ~granted) : req;
    assign mconf     = (state == OFFER) ? (conf & ~granted) : conf;
    assign pick_cand = (|mconf) ? mconf : mreq;
    assign pick_ptr  = (state == OFFER) ? idx_inc : ptr;

    rr_pick #(
        .N   (CLAUSE_NUM),
        .LOG (CLAUSE_NUM_LOG)
    ) u_pick (
        .cand  (pick_cand),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        valid_nxt  = out_valid;
        idx_nxt    = out_idx;
        confl_nxt  = out_conflict;
        gnt_nxt    = '0;
        halted_nxt = halted;
        case (state)
            IDLE: begin
                if (pick_found && !flush) begin
                    valid_nxt = 1'b1;
                    idx_nxt   = pick_idx;
                    confl_nxt = |mconf;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    gnt_nxt = granted;
                    ptr_nxt = idx_inc;
                    if (out_conflict) begin
                        valid_nxt  = 1'b0;
                        halted_nxt = 1'b1;
                        state_nxt  = HALT;
                    end else if (pick_found) begin
                        idx_nxt   = pick_idx;
                        confl_nxt = |mconf;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt  = IDLE;
            valid_nxt  = 1'b0;
            ptr_nxt    = '0;
            halted_nxt = 1'b0;
            gnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            out_valid    <= 1'b0;
            out_idx      <= '0;
            out_conflict <= 1'b0;
            gnt_onehot   <= '0;
            halted       <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            out_valid    <= valid_nxt;
            out_idx      <= idx_nxt;
            out_conflict <= confl_nxt;
            gnt_onehot   <= gnt_nxt;
            halted       <= halted_nxt;
        end
    end
endmodule

// File: tb/tb_bcp_clause_arbiter.sv
// tb/tb_bcp_clause_arbiter.sv - directed-vector bench for bcp_clause_arbiter
module tb_bcp_clause_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] conf = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_conflict;
    logic [7:0] gnt_onehot;
    logic       halted;

    int vectors = 0;
    int miscompares = 0;
    int proto_errs = 0;

    bcp_clause_arbiter #(.CLAUSE_NUM(8), .CLAUSE_NUM_LOG(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .conf         (conf),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_idx      (out_idx),
        .out_conflict (out_conflict),
        .gnt_onehot   (gnt_onehot),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // requester contract: an offered bit must stay up until its grant
    always @(posedge clk) begin
        if (rst_n && out_valid && !flush && !conf[out_idx] && !(req[out_idx] && !out_conflict)) begin
            proto_errs++;
            $display("FAIL proto: offered idx %0d dropped before grant (req %h conf %h)", out_idx, req, conf);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; requesters drop their bits in the cycle their grant shows
    task automatic tick;
        @(posedge clk);
        #1;
        req  = req & ~gnt_onehot;
        conf = conf & ~gnt_onehot;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && out_valid; c++) tick();
        check("drain_done", out_valid, 0);
    endtask

    int         cnt[8];
    int         grants[$];
    logic [7:0] g;

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_idx", out_idx, 0);
        check("rst_conf", out_conflict, 0);
        check("rst_gnt", gnt_onehot, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;

        // basic grant: 0 then 2 back-to-back
        req = 8'b0000_0101;
        out_ready = 1'b1;
        tick();
        check("basic_v0", out_valid, 1);
        check("basic_i0", out_idx, 0);
        check("basic_g0", gnt_onehot, 0);
        tick();
        check("basic_g1", gnt_onehot, 8'h01);
        check("basic_i1", out_idx, 2);
        check("basic_v1", out_valid, 1);
        tick();
        check("basic_g2", gnt_onehot, 8'h04);
        check("basic_v2", out_valid, 0);
        tick();
        check("basic_g3", gnt_onehot, 0);

        // fairness and wrap with reassertion two cycles after each grant
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        req = 8'hFF;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && grants.size() < 10; c++) begin
            tick();
            g = gnt_onehot;
            if (!$onehot0(g)) check("fair_onehot", g, 0);
            for (int i = 0; i < 8; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) req[i] = 1'b1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (g[i]) begin
                    grants.push_back(i);
                    cnt[i] = 2;
                end
            end
        end
        check("fair_count", grants.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < grants.size()) check("fair_order", grants[k], k % 8);
        end
        drain();

        // backpressure: idx 3 held while other bits toggle
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        req = 8'h08;
        tick();
        check("bp_offer", out_idx, 3);
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: req = 8'h09;
                1: req = 8'hF8;
                2: req = 8'hAD;
                default: req = 8'h48;
            endcase
            tick();
            check("bp_idx", out_idx, 3);
            check("bp_valid", out_valid, 1);
            check("bp_gnt", gnt_onehot, 0);
        end
        req = 8'h08;
        out_ready = 1'b1;
        tick();
        check("bp_accept", gnt_onehot, 8'h08);
        check("bp_after", out_valid, 0);

        // conflict priority and halt until flush
        out_ready = 1'b0;
        req = 8'h10;
        conf = 8'h04;
        tick();
        check("cf_flag", out_conflict, 1);
        check("cf_idx", out_idx, 2);
        out_ready = 1'b1;
        tick();
        check("cf_gnt", gnt_onehot, 8'h04);
        check("cf_halted", halted, 1);
        check("cf_valid", out_valid, 0);
        req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("halt_valid", out_valid, 0);
            check("halt_gnt", gnt_onehot, 0);
            check("halt_flag", halted, 1);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_halted", halted, 0);
        out_ready = 1'b0;
        tick();
        check("post_flush_idx", out_idx, 0);
        check("post_flush_valid", out_valid, 1);
        drain();

        // flush during an accepted offer of idx 5
        out_ready = 1'b0;
        req = 8'h20;
        tick();
        check("fm_offer", out_idx, 5);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fm_gnt", gnt_onehot, 0);
        check("fm_valid", out_valid, 0);
        out_ready = 1'b0;
        req = 8'hA0;
        tick();
        check("fm_ptr_pick", out_idx, 5);
        drain();

        // async reset in the middle of an offer
        out_ready = 1'b0;
        req = 8'h02;
        tick();
        check("ar_offer", out_idx, 1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_gnt", gnt_onehot, 0);
        check("ar_halted", halted, 0);
        check("ar_idx", out_idx, 0);
        req = 8'h80;
        #1 rst_n = 1'b1;
        tick();
        check("ar_rel_valid", out_valid, 1);
        check("ar_rel_idx", out_idx, 7);
        drain();

        check("protocol", proto_errs, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcp_clause_arbiter.md
Name: bcp_clause_arbiter

Overview:
- Round-robin arbiter that shares the single BCP implication/conflict return path between the `clause_num clause evaluation units.
- Each clause unit raises a request when it derives a unit implication, or a conflict when it becomes falsified.
- The arbiter picks one clause, offers its index downstream with a valid/ready handshake, and returns a one-hot grant that retires that clause's request.
- Conflicts take priority. A taken conflict halts arbitration until the backtrack flush.

Parameters:
- CLAUSE_NUM, default `clause_num (8): number of clause units and width of the request, conflict and grant vectors.
- CLAUSE_NUM_LOG, default `clause_num_log (3): width of the clause index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  CLAUSE_NUM  per-clause implication request; level, held by the clause unit until its grant bit pulses.
- conf  input  CLAUSE_NUM  per-clause conflict flag; level, same hold rule as req.
- flush  input  1  backtrack pulse; aborts any offer, clears halt, resets the pointer.
- out_ready  input  1  downstream accepts the current offer.
- out_valid  output  1  offer present.
- out_idx  output  CLAUSE_NUM_LOG  offered clause index.
- out_conflict  output  1  offer is a conflict, not an implication.
- gnt_onehot  output  CLAUSE_NUM  one-cycle pulse, one-hot at out_idx, in the cycle after acceptance.
- halted  output  1  a conflict was accepted; waiting for flush.

Behaviour:
- Reset (asynchronous, while rst_n=0): state=IDLE, pointer=0, out_valid=0, out_idx=0, out_conflict=0, gnt_onehot=0, halted=0.
- Pick function:
  - Candidate vector is conf if conf!=0, otherwise req.
  - Search starts at pointer and goes upward modulo CLAUSE_NUM; the first set bit wins.
  - Example wrap-around: pointer=6, candidates 8'b0000_0011 -> picks 0.
- IDLE:
  - Candidates nonzero and flush=0 -> register pick into out_idx/out_conflict, out_valid=1, go OFFER.
  - Latency: a request seen at edge t gives out_valid high after edge t.
- OFFER:
  - out_idx and out_conflict stay stable while out_ready=0, regardless of changes on req/conf.
  - On out_valid && out_ready:
    - pulse gnt_onehot = 1<<out_idx for one cycle;
    - pointer = out_idx+1 mod CLAUSE_NUM (CLAUSE_NUM-1 wraps to 0).
  - Accepted offer was a conflict -> out_valid=0, halted=1, go HALT.
  - Accepted offer was an implication -> masked candidates (req/conf with the just-granted bit cleared) are re-picked from the new pointer in the same edge.
    - Masked candidates nonzero: stay in OFFER with the new index (back-to-back, one offer per cycle).
    - Masked candidates zero: out_valid=0, go IDLE.
  - A conflict arriving while an implication offer is stalled does not preempt it. The conflict wins at the next pick.
- HALT:
  - req and conf are ignored; out_valid=0.
  - flush -> halted=0, pointer=0, go IDLE.
- flush in any state has highest priority:
  - next state IDLE, out_valid=0, pointer=0, halted=0;
  - no grant pulse, even if out_ready=1 in the same cycle.
- Requester contract: the clause unit drops its req/conf bit in the cycle its gnt_onehot bit is high. A bit dropped while offered and not yet granted is a protocol violation, flagged by a bench assertion. The RTL does not recover from it.
- Simultaneous req and conf on the same clause: conf wins.
- gnt_onehot is zero in every cycle without an accept. It is never more than one-hot.

Decomposition:
- Shared package bcp_pkg:
  - clause_idx_t (logic [CLAUSE_NUM_LOG-1:0]);
  - clause_vec_t (logic [CLAUSE_NUM-1:0]);
  - arb_state_t enum {IDLE, OFFER, HALT}.
- The `clause_num / `clause_num_log macros remain the single source for widths.
- Sub-module rr_pick (purely combinational):
  - inputs: candidate vector, pointer;
  - outputs: found, index;
  - implemented as a rotate, priority encode, un-rotate.
  - Instantiated once for the IDLE pick and the back-to-back re-pick.

Test Plan:
- Basic grant: reset, req=8'b0000_0101 held, out_ready=1.
  - Expect idx 0 (gnt 8'h01), then idx 2 (gnt 8'h04) back-to-back, then out_valid=0.
- Fairness/wrap: req=8'hFF with each bit dropped on its grant and reasserted 2 cycles later.
  - Expect grant order 0,1,...,7,0,1; no index granted twice before all others.
- Backpressure: offer idx 3, out_ready=0 for 4 cycles while req toggles other bits.
  - Expect out_idx=3 stable, out_valid=1, gnt_onehot=0; ready=1 gives gnt 8'h08 in the next cycle.
- Conflict priority: req=8'h10 and conf=8'h04 in the same cycle from IDLE.
  - Expect out_conflict=1, idx 2; accept gives halted=1.
  - Then req=8'hFF gives no offer. flush gives halted=0, and the next pick starts at 0.
- Flush mid-offer: offering idx 5 with out_ready=1 and flush=1 in the same cycle.
  - Expect no grant, out_valid=0 next cycle, pointer=0.
- Async reset: assert rst_n=0 mid-OFFER, between clock edges.
  - Expect out_valid, gnt_onehot, halted, out_idx all 0 immediately.
  - After release with req=8'h80: idx 7 offered one cycle later.
